// File: rtl/jtag_dr_controller_pkg.sv
// Shared encodings and helpers for the JTAG IR/DR controller.
package jtag_dr_controller_pkg;

    // Instruction encodings (4-bit reference width, cast to IR_WIDTH at use)
    localparam logic [3:0] IR_ABORT   = 4'b1000;
    localparam logic [3:0] IR_IDCODE  = 4'b1110;
    localparam logic [3:0] IR_BYPASS  = 4'b1111;
    localparam logic [3:0] IR_USER    = 4'b0100;

    // Pattern loaded into the IR shift register on Capture-IR
    localparam logic [1:0] IR_CAPTURE = 2'b01;

    // Raw TAP strobes as seen from the TAP state machine
    typedef struct packed {
        logic tlr;
        logic update_ir;
        logic capture_ir;
        logic shift_ir;
        logic update_dr;
        logic capture_dr;
        logic shift_dr;
    } tap_strobes_t;

    // Single resolved operation for the current tck cycle
    typedef enum logic [2:0] {
        OpNone,
        OpTlr,
        OpUpdateIr,
        OpCaptureIr,
        OpShiftIr,
        OpUpdateDr,
        OpCaptureDr,
        OpShiftDr
    } tap_op_e;

    // Data register selected by the held instruction
    typedef enum logic [1:0] {
        DrBypass,
        DrIdcode,
        DrUser
    } dr_sel_e;

    // Strobes should be exclusive; if not, the highest-priority one wins.
    function automatic tap_op_e prioritise(input tap_strobes_t s);
        if (s.tlr)        return OpTlr;
        if (s.update_ir)  return OpUpdateIr;
        if (s.capture_ir) return OpCaptureIr;
        if (s.shift_ir)   return OpShiftIr;
        if (s.update_dr)  return OpUpdateDr;
        if (s.capture_dr) return OpCaptureDr;
        if (s.shift_dr)   return OpShiftDr;
        return OpNone;
    endfunction

endpackage

// File: rtl/jtag_dr_controller_if.sv
// TAP-side strobe/serial bundle between the TAP state machine and the IR/DR controller.
interface jtag_dr_controller_if;

    logic tlr;
    logic capture_ir;
    logic shift_ir;
    logic update_ir;
    logic capture_dr;
    logic shift_dr;
    logic update_dr;
    logic tdi;
    logic tdo;
    logic tdo_en;

    // TAP state machine side
    modport master (
        output tlr, capture_ir, shift_ir, update_ir,
        output capture_dr, shift_dr, update_dr, tdi,
        input  tdo, tdo_en
    );

    // IR/DR controller side
    modport slave (
        input  tlr, capture_ir, shift_ir, update_ir,
        input  capture_dr, shift_dr, update_dr, tdi,
        output tdo, tdo_en
    );

endinterface

// File: rtl/jtag_dr_controller_shift_reg.sv
// Capture/shift register: parallel load, right shift with serial input at the MSB, parallel out.
module jtag_dr_controller_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_capture,
    input  logic             i_shift,
    input  logic             i_tdi,
    input  logic [WIDTH-1:0] i_capture_val,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_shifted;

    generate
        if (WIDTH == 1) begin : g_single
            assign w_shifted = i_tdi;
        end else begin : g_multi
            assign w_shifted = {i_tdi, r_q[WIDTH-1:1]};
        end
    endgenerate

    // Capture takes precedence over shift; otherwise hold
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_capture) begin
            r_q <= i_capture_val;
        end else if (i_shift) begin
            r_q <= w_shifted;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/jtag_dr_controller.sv
// JTAG IR/DR controller: holds and decodes the instruction, sequences capture/shift/update on
// the selected data register, muxes TDO and issues user-update and abort pulses.
module jtag_dr_controller
    import jtag_dr_controller_pkg::*;
#(
    parameter int unsigned IR_WIDTH     = 4,
    parameter logic [31:0] IDCODE_VALUE = 32'h000F_AF01,
    parameter int unsigned USER_WIDTH   = 8
) (
    input  logic                  i_tck,
    input  logic                  i_trst_n,
    jtag_dr_controller_if.slave   tap,
    input  logic [USER_WIDTH-1:0] i_user_capture,
    output logic [IR_WIDTH-1:0]   o_ir,
    output logic [USER_WIDTH-1:0] o_user_data,
    output logic                  o_user_update,
    output logic                  o_abort
);

    localparam logic [IR_WIDTH-1:0] IrIdcode  = IR_WIDTH'(IR_IDCODE);
    localparam logic [IR_WIDTH-1:0] IrUser    = IR_WIDTH'(IR_USER);
    localparam logic [IR_WIDTH-1:0] IrAbort   = IR_WIDTH'(IR_ABORT);
    localparam logic [IR_WIDTH-1:0] IrCapture = IR_WIDTH'(IR_CAPTURE);

    tap_strobes_t          w_strobes;
    tap_op_e               w_op;
    dr_sel_e               w_dr_sel;
    logic                  w_is_abort;

    logic [IR_WIDTH-1:0]   w_ir_shift;
    logic [31:0]           w_idcode_q;
    logic [USER_WIDTH-1:0] w_user_q;
    logic                  w_idcode_unused;

    logic [IR_WIDTH-1:0]   r_ir;
    logic                  r_bypass;
    logic                  r_update_dr_prev;
    logic [USER_WIDTH-1:0] r_user_data;
    logic                  r_user_update;
    logic                  r_abort;

    logic                  w_update_entry;
    logic                  w_sel_lsb;

    assign w_strobes = '{
        tlr:        tap.tlr,
        update_ir:  tap.update_ir,
        capture_ir: tap.capture_ir,
        shift_ir:   tap.shift_ir,
        update_dr:  tap.update_dr,
        capture_dr: tap.capture_dr,
        shift_dr:   tap.shift_dr
    };
    assign w_op = prioritise(w_strobes);

    // Instruction shift register
    jtag_dr_controller_shift_reg #(
        .WIDTH (IR_WIDTH)
    ) u_ir_sr (
        .i_clk         (i_tck),
        .i_rst_n       (i_trst_n),
        .i_capture     (w_op == OpCaptureIr),
        .i_shift       (w_op == OpShiftIr),
        .i_tdi         (tap.tdi),
        .i_capture_val (IrCapture),
        .o_q           (w_ir_shift)
    );

    // Held instruction: IDCODE out of reset and on Test-Logic-Reset
    always_ff @(posedge i_tck or negedge i_trst_n) begin
        if (!i_trst_n) begin
            r_ir <= IrIdcode;
        end else if (w_op == OpTlr) begin
            r_ir <= IrIdcode;
        end else if (w_op == OpUpdateIr) begin
            r_ir <= w_ir_shift;
        end
    end

    // Instruction decode; ABORT and undefined codes fall back to BYPASS
    always_comb begin
        w_dr_sel = DrBypass;
        if (r_ir == IrIdcode) begin
            w_dr_sel = DrIdcode;
        end else if (r_ir == IrUser) begin
            w_dr_sel = DrUser;
        end
    end
    assign w_is_abort = (r_ir == IrAbort);

    // IDCODE data register
    jtag_dr_controller_shift_reg #(
        .WIDTH (32)
    ) u_idcode_sr (
        .i_clk         (i_tck),
        .i_rst_n       (i_trst_n),
        .i_capture     ((w_op == OpCaptureDr) && (w_dr_sel == DrIdcode)),
        .i_shift       ((w_op == OpShiftDr) && (w_dr_sel == DrIdcode)),
        .i_tdi         (tap.tdi),
        .i_capture_val (IDCODE_VALUE),
        .o_q           (w_idcode_q)
    );

    // Only the serial end of IDCODE is observed
    assign w_idcode_unused = ^w_idcode_q[31:1];

    // USER data register
    jtag_dr_controller_shift_reg #(
        .WIDTH (USER_WIDTH)
    ) u_user_sr (
        .i_clk         (i_tck),
        .i_rst_n       (i_trst_n),
        .i_capture     ((w_op == OpCaptureDr) && (w_dr_sel == DrUser)),
        .i_shift       ((w_op == OpShiftDr) && (w_dr_sel == DrUser)),
        .i_tdi         (tap.tdi),
        .i_capture_val (i_user_capture),
        .o_q           (w_user_q)
    );

    // One-bit bypass register: cleared on capture, follows TDI while shifting
    always_ff @(posedge i_tck or negedge i_trst_n) begin
        if (!i_trst_n) begin
            r_bypass <= 1'b0;
        end else if ((w_op == OpCaptureDr) && (w_dr_sel == DrBypass)) begin
            r_bypass <= 1'b0;
        end else if ((w_op == OpShiftDr) && (w_dr_sel == DrBypass)) begin
            r_bypass <= tap.tdi;
        end
    end

    // Update-DR acts only on the first cycle of a (possibly held) update strobe
    assign w_update_entry = (w_op == OpUpdateDr) && !r_update_dr_prev;

    // Update edge tracking, user data write and one-cycle pulses
    always_ff @(posedge i_tck or negedge i_trst_n) begin
        if (!i_trst_n) begin
            r_update_dr_prev <= 1'b0;
            r_user_data      <= '0;
            r_user_update    <= 1'b0;
            r_abort          <= 1'b0;
        end else begin
            r_update_dr_prev <= (w_op == OpUpdateDr);
            r_user_update    <= w_update_entry && (w_dr_sel == DrUser);
            r_abort          <= w_update_entry && w_is_abort;
            if (w_update_entry && (w_dr_sel == DrUser)) begin
                r_user_data <= w_user_q;
            end
        end
    end

    // Serial end of the selected data register
    always_comb begin
        w_sel_lsb = r_bypass;
        unique case (w_dr_sel)
            DrIdcode: w_sel_lsb = w_idcode_q[0];
            DrUser:   w_sel_lsb = w_user_q[0];
            default:  w_sel_lsb = r_bypass;
        endcase
    end

    // TDO follows the raw shift strobes with no register stage
    assign tap.tdo    = tap.shift_ir ? w_ir_shift[0] : (tap.shift_dr ? w_sel_lsb : 1'b0);
    assign tap.tdo_en = tap.shift_ir | tap.shift_dr;

    assign o_ir          = r_ir;
    assign o_user_data   = r_user_data;
    assign o_user_update = r_user_update;
    assign o_abort       = r_abort;

endmodule
